// File: rtl/field_sequencer.sv
// Field nibble sequencer: decodes a register field code into a nibble range and issues
// one nibble index per consumer ack. Define FIELD_SEQ_REVERSE_EN to honour dir.
module field_sequencer #(
  parameter int NIBBLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] field,
  input  logic [3:0] p_reg,
  input  logic       dir,
  input  logic       abort,
  input  logic       nib_ack,
  output logic       ready,
  output logic       nib_valid,
  output logic [3:0] nib_idx,
  output logic       nib_first,
  output logic       nib_last,
  output logic [3:0] mask_start,
  output logic [3:0] mask_width,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] TOP = 4'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] lo;
    logic [3:0] hi;
  } span_t;

  function automatic span_t decode_field(input logic [3:0] f, input logic [3:0] p);
    span_t s;
    s.legal = 1'b1;
    s.lo    = 4'd0;
    s.hi    = 4'd0;
    case (f)
      4'd0: begin s.lo = p; s.hi = p; end
      4'd1: s.hi = p;
      4'd2: begin s.lo = 4'd2; s.hi = 4'd2; end
      4'd3: s.hi = 4'd2;
      4'd4: begin s.lo = TOP; s.hi = TOP; end
      4'd5: begin s.lo = 4'd3; s.hi = TOP - 4'd1; end
      4'd6: s.hi = 4'd1;
      4'd7: s.hi = TOP;
      4'd8: s.hi = 4'd4;
      default: s.legal = 1'b0;
    endcase
    return s;
  endfunction

  state_t     state_q, state_d;
  span_t      span;
  logic [3:0] idx_q, end_q, idx_step;
  logic       first_q, load, advance, at_end;

`ifdef FIELD_SEQ_REVERSE_EN
  logic       dir_q;
  assign idx_step = dir_q ? idx_q - 4'd1 : idx_q + 4'd1;
`else
  logic       unused_dir;
  assign unused_dir = dir;
  assign idx_step   = idx_q + 4'd1;
`endif

  assign span   = decode_field(field, p_reg);
  assign at_end = (idx_q == end_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    advance   = 1'b0;
    ready     = 1'b0;
    nib_valid = 1'b0;
    nib_first = 1'b0;
    nib_last  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (span.legal) begin
            state_d = RUN;
            load    = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
      end
      RUN: begin
        nib_valid = 1'b1;
        nib_first = first_q;
        nib_last  = at_end;
        // abort wins over a simultaneous ack
        if (abort) begin
          state_d = IDLE;
        end else if (nib_ack) begin
          if (at_end) state_d = DONE;
          else        advance = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= 4'd0;
      end_q      <= 4'd0;
      first_q    <= 1'b0;
      mask_start <= 4'd0;
      mask_width <= 4'd0;
`ifdef FIELD_SEQ_REVERSE_EN
      dir_q      <= 1'b0;
`endif
    end else if (load) begin
      mask_start <= span.lo;
      mask_width <= span.hi - span.lo;
      first_q    <= 1'b1;
`ifdef FIELD_SEQ_REVERSE_EN
      dir_q      <= dir;
      idx_q      <= dir ? span.hi : span.lo;
      end_q      <= dir ? span.lo : span.hi;
`else
      idx_q      <= span.lo;
      end_q      <= span.hi;
`endif
    end else if (advance) begin
      idx_q   <= idx_step;
      first_q <= 1'b0;
    end
  end

  assign nib_idx = idx_q;

endmodule

// File: tb/tb_field_sequencer.sv
// Self-checking bench for field_sequencer: directed vector table, hand-written abort/reset
// sequences and randomized runs against a queue-based reference model.
module tb_field_sequencer;

`ifdef FIELD_SEQ_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, dir, abort, nib_ack;
  logic [3:0] field, p_reg;
  logic       ready, nib_valid, nib_first, nib_last, done, err;
  logic [3:0] nib_idx, mask_start, mask_width;

  int errors = 0;
  int checks = 0;
  int ms_model = 0;
  int mw_model = 0;

  field_sequencer #(.NIBBLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .field(field), .p_reg(p_reg), .dir(dir),
    .abort(abort), .nib_ack(nib_ack), .ready(ready), .nib_valid(nib_valid),
    .nib_idx(nib_idx), .nib_first(nib_first), .nib_last(nib_last),
    .mask_start(mask_start), .mask_width(mask_width), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Field rules as a plain lookup: returns 0 for illegal codes.
  function automatic bit model_span(input int f, input int p, output int lo, output int hi);
    lo = 0;
    hi = 0;
    case (f)
      0: begin lo = p; hi = p; end
      1: hi = p;
      2: begin lo = 2; hi = 2; end
      3: hi = 2;
      4: begin lo = 15; hi = 15; end
      5: begin lo = 3; hi = 14; end
      6: hi = 1;
      7: hi = 15;
      8: hi = 4;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_valid"}, nib_valid, 0);
    chk({tag, "_idx"}, nib_idx, 0);
    chk({tag, "_first"}, nib_first, 0);
    chk({tag, "_last"}, nib_last, 0);
    chk({tag, "_mstart"}, mask_start, 0);
    chk({tag, "_mwidth"}, mask_width, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Entered and left at a negedge with the DUT idle. mode: 0 ack always, 1 every other, 2 random.
  task automatic run_seq(input logic [3:0] f, input logic [3:0] p, input logic d, input int mode,
                         input int ems, input int emw, input bit eerr);
    int q[$];
    int k, cyc;
    bit ph, ack;
    chk("ready_before_start", ready, 1);
    start   = 1'b1;
    field   = f;
    p_reg   = p;
    dir     = d;
    nib_ack = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    start   = 1'b0;
    nib_ack = 1'b0;
    if (eerr) begin
      chk("err_pulse", err, 1);
      chk("err_valid", nib_valid, 0);
      chk("err_ready", ready, 0);
      chk("err_mstart", mask_start, ems);
      chk("err_mwidth", mask_width, emw);
      @(negedge clk);
      chk("err_clear", err, 0);
      chk("err_ready_back", ready, 1);
      chk("err_mwidth_held", mask_width, emw);
    end else begin
      ms_model = ems;
      mw_model = emw;
      for (int i = ems; i <= ems + emw; i++) begin
        if (d && REV) q.push_front(i);
        else          q.push_back(i);
      end
      k = 0; cyc = 0; ph = 1'b0;
      while (k < q.size() && cyc < 200) begin
        chk("valid", nib_valid, 1);
        chk("idx", nib_idx, q[k]);
        chk("first", nib_first, int'(k == 0));
        chk("last", nib_last, int'(k == q.size() - 1));
        chk("mstart", mask_start, ems);
        chk("mwidth", mask_width, emw);
        chk("done_early", done, 0);
        case (mode)
          0:       ack = 1'b1;
          1:       begin ack = ph; ph = !ph; end
          default: ack = 1'($urandom_range(0, 1));
        endcase
        nib_ack = ack;
        @(negedge clk);
        if (ack) k++;
        cyc++;
      end
      nib_ack = 1'b0;
      if (k < q.size()) chk("seq_timeout", k, q.size());
      chk("done_pulse", done, 1);
      chk("done_valid", nib_valid, 0);
      chk("done_ready", ready, 0);
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("idle_ready", ready, 1);
    end
  endtask

  typedef struct {
    logic [3:0] f;
    logic [3:0] p;
    logic       d;
    int         mode;
    int         ems;
    int         emw;
    bit         eerr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lo, hi, f, p;
    bit legal;
    vecs[0]  = '{4'd8,  4'd0, 1'b0, 0, 0,  4,  1'b0};  // A, ack held
    vecs[1]  = '{4'd0,  4'd9, 1'b0, 0, 9,  0,  1'b0};  // P single nibble
    vecs[2]  = '{4'd5,  4'd0, 1'b1, 1, 3,  11, 1'b0};  // M descending, ack alternate
    vecs[3]  = '{4'd12, 4'd0, 1'b0, 0, 3,  11, 1'b1};  // illegal, mask unchanged
    vecs[4]  = '{4'd2,  4'd7, 1'b1, 0, 2,  0,  1'b0};  // XS
    vecs[5]  = '{4'd1,  4'd5, 1'b1, 2, 0,  5,  1'b0};  // WP
    vecs[6]  = '{4'd4,  4'd0, 1'b0, 1, 15, 0,  1'b0};  // S
    vecs[7]  = '{4'd6,  4'd3, 1'b1, 0, 0,  1,  1'b0};  // B
    vecs[8]  = '{4'd3,  4'd0, 1'b0, 2, 0,  2,  1'b0};  // X
    vecs[9]  = '{4'd7,  4'd0, 1'b0, 2, 0,  15, 1'b0};  // W
    vecs[10] = '{4'd9,  4'd0, 1'b1, 0, 0,  15, 1'b1};  // lowest illegal code
    vecs[11] = '{4'd1,  4'd0, 1'b0, 0, 0,  0,  1'b0};  // WP with p=0

    rst_n = 1'b0; start = 1'b0; field = 4'd0; p_reg = 4'd0; dir = 1'b0;
    abort = 1'b0; nib_ack = 1'b0;
    #12;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_seq(vecs[i].f, vecs[i].p, vecs[i].d, vecs[i].mode, vecs[i].ems, vecs[i].emw, vecs[i].eerr);

    // W aborted at idx 5 with a simultaneous ack; stray start in RUN and abort in IDLE ignored
    start = 1'b1; field = 4'd7; p_reg = 4'd0; dir = 1'b0; abort = 1'b1; nib_ack = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      chk("ab_valid", nib_valid, 1);
      chk("ab_idx", nib_idx, k);
      chk("ab_mwidth", mask_width, 15);
      start = (k == 2);
      field = (k == 2) ? 4'd0 : 4'd7;
      abort = (k == 5);
      nib_ack = 1'b1;
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; nib_ack = 1'b0;
    chk("ab_ready", ready, 1);
    chk("ab_valid_off", nib_valid, 0);
    chk("ab_no_done", done, 0);
    chk("ab_mstart", mask_start, 0);
    @(negedge clk);
    chk("ab_no_done2", done, 0);
    @(negedge clk);
    chk("ab_no_done3", done, 0);
    ms_model = 0; mw_model = 15;

    // reset mid-RUN of W, then a fresh A sequence right after release
    start = 1'b1; field = 4'd7; dir = 1'b0; nib_ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_idx", nib_idx, 2);
    #2;
    rst_n = 1'b0;
    nib_ack = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    ms_model = 0; mw_model = 0;
    run_seq(4'd8, 4'd0, 1'b0, 0, 0, 4, 1'b0);

    for (int n = 0; n < 40; n++) begin
      f = $urandom_range(0, 11);
      p = $urandom_range(0, 15);
      legal = model_span(f, p, lo, hi);
      if (legal) run_seq(4'(f), 4'(p), 1'($urandom_range(0, 1)), $urandom_range(0, 2), lo, hi - lo, 1'b0);
      else       run_seq(4'(f), 4'(p), 1'($urandom_range(0, 1)), $urandom_range(0, 2), ms_model, mw_model, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
